// File: rtl/async_pkg.sv
// Shared definitions for the async_* operator blocks: op encodings,
// FSM state type and a constant-safe log2 helper.
package async_pkg;

    // Arithmetic operation encodings, selected from the string parameter.
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    // Shared-operator controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter/port width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/async_shared_operator_if.sv
// Client-side bus of the shared operator: flattened per-client request
// and operand lanes, one-hot ack pulse, shared result and status.
interface async_shared_operator_if #(
    parameter int data_width  = 32,
    parameter int num_clients = 4
);
    import async_pkg::*;

    logic [num_clients-1:0]            req;
    logic [data_width*num_clients-1:0] din_a;
    logic [data_width*num_clients-1:0] din_b;
    logic [num_clients-1:0]            ack;
    logic [data_width-1:0]             dout;
    logic                              busy;
    logic [clog2(num_clients)-1:0]     grant_id;

    // Requesters drive requests and operands.
    modport master (
        output req, din_a, din_b,
        input  ack, dout, busy, grant_id
    );

    // The shared operator answers them.
    modport slave (
        input  req, din_a, din_b,
        output ack, dout, busy, grant_id
    );

endinterface

// File: rtl/async_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester found searching
// upward from ptr_i (modulo num_clients) wins. The pointer register lives
// in the parent so the arbiter itself is stateless.
module async_rr_arbiter
    import async_pkg::*;
#(
    parameter int num_clients = 4
) (
    input  logic [num_clients-1:0]        req_i,
    input  logic [clog2(num_clients)-1:0] ptr_i,
    output logic [num_clients-1:0]        grant_o,
    output logic [clog2(num_clients)-1:0] idx_o,
    output logic                          valid_o
);

    localparam int id_w = clog2(num_clients);

    int cand;

    // Priority search starting at the pointer, wrapping past the top client.
    // NOTE: every output gets a default before the search so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 0; k < num_clients; k++) begin
            cand = (int'(ptr_i) + k) % num_clients;
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = id_w'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_shared_operator.sv
// One add/sub/mul unit time-shared round-robin among num_clients
// req/ack producers, one operation in flight. The unit is combinational on
// latched operands; its latency is modelled by the EXEC down-counter.
module async_shared_operator
    import async_pkg::*;
#(
    parameter int    data_width  = 32,
    parameter int    num_clients = 4,
    parameter string op          = "mul",
    parameter int    latency     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    async_shared_operator_if.slave   bus
);

    localparam int id_w  = clog2(num_clients);
    localparam int cnt_w = clog2(latency + 1);

    localparam logic [1:0] op_sel = (op == "add") ? OP_ADD :
                                    (op == "sub") ? OP_SUB : OP_MUL;

    state_t                  state_q, state_d;
    logic [cnt_w-1:0]        cnt_q, cnt_d;
    logic [id_w-1:0]         ptr_q, ptr_d;
    logic [id_w-1:0]         grant_id_q, grant_id_d;
    logic [num_clients-1:0]  ack_q, ack_d;
    logic [num_clients-1:0]  gnt_oh_q, gnt_oh_d;
    logic [data_width-1:0]   a_q, a_d, b_q, b_d;
    logic [data_width-1:0]   dout_q, dout_d;
    logic [data_width-1:0]   result;

    logic [num_clients-1:0]  eligible;
    logic [num_clients-1:0]  arb_grant;
    logic [id_w-1:0]         arb_idx;
    logic                    arb_valid;

    // The client being acked still holds req this cycle; keep it out.
    assign eligible = bus.req & ~ack_q;

    async_rr_arbiter #(
        .num_clients (num_clients)
    ) u_arb (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Shared arithmetic unit; results wrap modulo 2^data_width.
    always_comb begin
        result = '0;
        unique case (op_sel)
            OP_ADD:  result = a_q + b_q;
            OP_SUB:  result = a_q - b_q;
            default: result = a_q * b_q;
        endcase
    end

    // Next-state and output logic of the grant/execute/respond FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        ack_d      = ack_q;
        gnt_oh_d   = gnt_oh_q;
        a_d        = a_q;
        b_d        = b_q;
        dout_d     = dout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    a_d        = bus.din_a[int'(arb_idx)*data_width +: data_width];
                    b_d        = bus.din_b[int'(arb_idx)*data_width +: data_width];
                    grant_id_d = arb_idx;
                    gnt_oh_d   = arb_grant;
                    cnt_d      = cnt_w'(latency - 1);
                    ptr_d      = (arb_idx == id_w'(num_clients - 1)) ? '0 : arb_idx + 1'b1;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    dout_d  = result;
                    ack_d   = gnt_oh_q;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                ack_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                ack_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and result registers with synchronous reset; reset drops any
    // in-flight operation without acking it.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant_id_q <= '0;
            ack_q      <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
        end
    end

    // Operand and grant latches, loaded at every grant before being read.
    // NOTE: these datapath registers are deliberately not reset; they are
    // always written in IDLE before EXEC/RESP consume them.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        gnt_oh_q <= gnt_oh_d;
    end

    assign bus.ack      = ack_q;
    assign bus.dout     = dout_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_async_shared_operator.sv
// Directed testbench for async_shared_operator: a mul instance (latency 2)
// carries the arbitration scenarios, sub and add instances cover wrap-around.
`timescale 1ns/1ps
module tb_async_shared_operator;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    async_shared_operator_if #(.data_width(32), .num_clients(4)) m_if ();
    async_shared_operator_if #(.data_width(32), .num_clients(4)) s_if ();
    async_shared_operator_if #(.data_width(32), .num_clients(4)) a_if ();

    async_shared_operator #(.data_width(32), .num_clients(4), .op("mul"), .latency(2))
        u_mul (.clk(clk), .rst(rst), .bus(m_if));
    async_shared_operator #(.data_width(32), .num_clients(4), .op("sub"), .latency(2))
        u_sub (.clk(clk), .rst(rst), .bus(s_if));
    async_shared_operator #(.data_width(32), .num_clients(4), .op("add"), .latency(1))
        u_add (.clk(clk), .rst(rst), .bus(a_if));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_ops(input int c, input logic [31:0] a, input logic [31:0] b);
        m_if.din_a[c*32 +: 32] = a;
        m_if.din_b[c*32 +: 32] = b;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v == (4'b0001 << i)) return i;
        end
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  ack_v;
        logic [31:0] dout_v;
        int          ack_cyc;
        int          busy_cnt;
        int          n_ack;
        int          last_cyc;
        int          prev_idx;
        int          reraise;
        int          idx;
        int          drop_at;
        logic [3:0]  ack1_v, ack2_v;
        logic [31:0] dout1_v, dout2_v;
        int          cyc1, cyc2;
        logic [1:0]  gid_v;

        m_if.req = '0; m_if.din_a = '0; m_if.din_b = '0;
        s_if.req = '0; s_if.din_a = '0; s_if.din_b = '0;
        a_if.req = '0; a_if.din_a = '0; a_if.din_b = '0;
        reset_all();

        // Reset state held through 10 idle cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ack", m_if.ack, 4'b0000);
            check("idle_busy", m_if.busy, 1'b0);
            check("idle_dout", m_if.dout, 32'd0);
            check("idle_grant_id", m_if.grant_id, 2'd0);
        end

        // Single request from client 2: 7*6.
        set_ops(2, 32'd7, 32'd6);
        m_if.req = 4'b0100;
        busy_cnt = 0; ack_cyc = -1; ack_v = '0; dout_v = '0; n_ack = 0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (m_if.busy) busy_cnt++;
            if (m_if.ack != 4'b0000) begin
                n_ack++;
                ack_cyc = c;
                ack_v   = m_if.ack;
                dout_v  = m_if.dout;
                m_if.req = 4'b0000;
            end
        end
        check("single_ack_cycle", ack_cyc, 3);
        check("single_ack_vec", ack_v, 4'b0100);
        check("single_dout", dout_v, 32'd42);
        check("single_busy_cycles", busy_cnt, 3);
        check("single_ack_count", n_ack, 1);
        check("single_grant_id", m_if.grant_id, 2'd2);
        check("single_dout_held", m_if.dout, 32'd42);

        // Mul overflow: 0x10000 squared truncates to zero.
        set_ops(0, 32'h0001_0000, 32'h0001_0000);
        m_if.req = 4'b0001;
        ack_v = '0; dout_v = 32'hdead_beef;
        for (int c = 0; c < 10 && ack_v == 4'b0000; c++) begin
            tick();
            if (m_if.ack != 4'b0000) begin
                ack_v  = m_if.ack;
                dout_v = m_if.dout;
                m_if.req = 4'b0000;
            end
        end
        check("mul_ovf_ack", ack_v, 4'b0001);
        check("mul_ovf_dout", dout_v, 32'd0);

        // Sub 0-1 (latency 2) and add 0xFFFFFFFF+2 (latency 1) in parallel.
        s_if.din_a[31:0] = 32'd0;
        s_if.din_b[31:0] = 32'd1;
        a_if.din_a[31:0] = 32'hFFFF_FFFF;
        a_if.din_b[31:0] = 32'd2;
        s_if.req = 4'b0001;
        a_if.req = 4'b0001;
        tick();
        check("add_busy_e0", a_if.busy, 1'b1);
        check("add_ack_e0", a_if.ack, 4'b0000);
        tick();
        check("add_ack_e1", a_if.ack, 4'b0001);
        check("add_dout", a_if.dout, 32'd1);
        check("sub_ack_e1", s_if.ack, 4'b0000);
        a_if.req = 4'b0000;
        tick();
        check("sub_ack_e2", s_if.ack, 4'b0001);
        check("sub_dout", s_if.dout, 32'hFFFF_FFFF);
        check("add_idle_e2", a_if.busy, 1'b0);
        s_if.req = 4'b0000;
        tick();
        check("sub_ack_clear", s_if.ack, 4'b0000);

        // Full contention: grants rotate 0,1,2,3,... four cycles apart.
        reset_all();
        for (int i = 0; i < 4; i++) set_ops(i, 32'(i + 1), 32'd10);
        m_if.req = 4'b1111;
        n_ack = 0; last_cyc = 0; prev_idx = -1; reraise = -1;
        for (int c = 1; c <= 60 && n_ack < 8; c++) begin
            tick();
            if (reraise >= 0) begin
                m_if.req[reraise] = 1'b1;
                reraise = -1;
            end
            if (m_if.ack != 4'b0000) begin
                idx = oh_idx(m_if.ack);
                check("rr_order", idx, n_ack % 4);
                check("rr_dout", m_if.dout, 32'((n_ack % 4 + 1) * 10));
                if (n_ack > 0) begin
                    check("rr_spacing", c - last_cyc, 4);
                    check("rr_no_repeat", idx == prev_idx, 1'b0);
                end
                if (idx >= 0) begin
                    m_if.req[idx] = 1'b0;
                    reraise = idx;
                end
                prev_idx = idx;
                last_cyc = c;
                n_ack++;
            end
        end
        check("rr_ack_count", n_ack, 8);
        m_if.req = 4'b0000;

        // Ack-cycle masking: client 1 holds req one cycle past its ack.
        reset_all();
        set_ops(1, 32'd3, 32'd5);
        set_ops(3, 32'd100, 32'd200);
        m_if.req = 4'b1010;
        n_ack = 0; drop_at = -1; gid_v = '0;
        ack1_v = '0; ack2_v = '0; dout1_v = '0; dout2_v = '0; cyc1 = -1; cyc2 = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 5) gid_v = m_if.grant_id;
            if (m_if.ack != 4'b0000) begin
                n_ack++;
                if (n_ack == 1) begin
                    ack1_v = m_if.ack; dout1_v = m_if.dout; cyc1 = c;
                    drop_at = c + 2;
                end else if (n_ack == 2) begin
                    ack2_v = m_if.ack; dout2_v = m_if.dout; cyc2 = c;
                    m_if.req[3] = 1'b0;
                end
            end
            if (c == drop_at) m_if.req[1] = 1'b0;
        end
        check("mask_first_ack", ack1_v, 4'b0010);
        check("mask_first_cycle", cyc1, 3);
        check("mask_first_dout", dout1_v, 32'd15);
        check("mask_next_grant", gid_v, 2'd3);
        check("mask_second_ack", ack2_v, 4'b1000);
        check("mask_second_cycle", cyc2, 7);
        check("mask_second_dout", dout2_v, 32'd20000);
        check("mask_ack_count", n_ack, 2);

        // Reset mid-EXEC: client 2's op is abandoned, ptr restarts at 0.
        reset_all();
        set_ops(2, 32'd9, 32'd9);
        m_if.req = 4'b0100;
        tick();
        check("rstx_grant_id", m_if.grant_id, 2'd2);
        check("rstx_busy", m_if.busy, 1'b1);
        set_ops(0, 32'd11, 32'd3);
        set_ops(3, 32'd2, 32'd2);
        m_if.req = 4'b1001;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstx_busy_after", m_if.busy, 1'b0);
        check("rstx_ack_after", m_if.ack, 4'b0000);
        check("rstx_gid_after", m_if.grant_id, 2'd0);
        n_ack = 0; ack1_v = '0; dout1_v = '0; cyc1 = -1; gid_v = 2'd3;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) gid_v = m_if.grant_id;
            if (m_if.ack == 4'b0100) n_ack++;
            if (m_if.ack != 4'b0000 && cyc1 < 0) begin
                ack1_v = m_if.ack; dout1_v = m_if.dout; cyc1 = c;
                m_if.req[oh_idx(m_if.ack) & 3] = 1'b0;
            end
        end
        m_if.req = 4'b0000;
        check("rstx_regrant_id", gid_v, 2'd0);
        check("rstx_first_ack", ack1_v, 4'b0001);
        check("rstx_first_cycle", cyc1, 3);
        check("rstx_first_dout", dout1_v, 32'd33);
        check("rstx_no_abandoned_ack", n_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
